bram_sdp_be: RTL and testbench
==============================

Name: bram_sdp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port, one read port.
- Adds per-byte write enables, a read-enable and read-valid pipeline, and an optional output register.
- Adds a hardware clear engine that fills every entry with CLEAR_VALUE after reset.
- Generic storage for line buffers, tile and palette tables, and CPU-visible memories in the video/NES datapath; replaces fixed 16x256 instances.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 0, 1 adds an output register stage, making read latency 2.
- CLEAR_ON_RESET, 1, 1 runs the clear engine after every reset.
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every entry by the clear engine.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write_addr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- write_enable  in  1  write strobe.
- write_byte_enable  in  NUM_LANES  lane i gates bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- read_addr  in  ADDR_WIDTH  read address.
- read_enable  in  1  issue a read this cycle.
- read_data  out  DATA_WIDTH  read result.
- read_valid  out  1  read_data holds the result of a read issued LAT cycles earlier.
- busy  out  1  clear in progress; user port inputs are ignored.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - read_data = 0.
  - read_valid = 0.
  - Output pipeline stage cleared.
  - busy = CLEAR_ON_RESET.
  - Clear counter = 0.
- Memory contents:
  - Not affected by reset itself.
  - With CLEAR_ON_RESET=0, contents persist across reset.
- State machine: states CLEAR and READY.
  - Reset: enter CLEAR if CLEAR_ON_RESET, else READY.
  - CLEAR:
    - Each cycle writes CLEAR_VALUE, all lanes, to mem[clr_cnt], then increments clr_cnt.
    - After writing address 2**ADDR_WIDTH-1, go to READY. busy is 0 on the following cycle.
    - Clear duration is exactly 2**ADDR_WIDTH cycles after reset is released; 256 cycles for the defaults.
  - Reset asserted mid-clear: counter returns to 0 and the clear restarts from address 0.
  - During CLEAR:
    - write_enable and read_enable are ignored.
    - read_valid stays 0.
    - read_data holds its value.
- Write, READY only:
  - When write_enable=1, for each lane i with write_byte_enable[i]=1, that lane of mem[write_addr] takes write_data's lane at the edge.
  - Lanes with enable 0 are unchanged.
  - write_enable=1 with all byte enables 0 is a no-op.
- Read, READY only:
  - LAT = 1 + OUT_REG.
  - read_enable=1 at edge N: read_data = mem[read_addr] at edge N+LAT-1, and read_valid=1 in the cycle after that edge.
  - read_valid is a LAT-deep shift of read_enable; back-to-back reads give one result per cycle.
  - read_enable=0: read_data holds its last value; read_valid=0.
- Read and write to the same address in the same cycle: read-first. The read returns the old contents, per lane. The new data is visible to reads issued from the next cycle on.
- Different addresses: fully independent; no stalls.
- Reads in flight at reset: discarded; read_valid=0 from the reset edge on.
- Width rules:
  - Addresses are unsigned; every address is in range, so no wrap handling is needed.
  - Elaboration fails if DATA_WIDTH % BYTE_WIDTH != 0 or OUT_REG > 1.
- Synthesis: storage infers block RAM. Byte lanes use a per-lane write loop inside one clocked process; no reset on the array.

Decomposition:
- Package bram_pkg holds:
  - the state enum bram_state_t {CLEAR, READY};
  - the function lanes(data_w, byte_w);
  - the shared parameter checks.
- Single module; the clear counter is small enough to stay inline.
- The read-valid pipeline is generated from OUT_REG.

Test Plan:
1. Defaults, clear: release reset, then read 0x00, 0x7F, 0xFF once busy falls.
   - busy stays 1 for exactly 256 cycles.
   - Each read returns 0x0000, with read_valid high 1 cycle after issue.
2. Byte enables: write 0xABCD to 0x10 with BE=11, then 0x12xx with BE=10; read 0x10 -> 0x12CD.
   - Then a write with BE=00; read 0x10 -> still 0x12CD.
3. Read-first, same-cycle collision: mem[0x20]=0x1111; write 0x2222 and read 0x20 in the same cycle -> read returns 0x1111; next read returns 0x2222.
4. Latency, OUT_REG=1: issue reads of 0x01..0x04 on 4 consecutive cycles with known contents.
   - read_valid rises exactly 2 cycles after the first issue.
   - Four consecutive valid words, in order.
5. Reset mid-clear: assert reset at clear count 100, release.
   - busy lasts a full 256 cycles from the release.
   - Entries 0..255 all equal CLEAR_VALUE=0x5A5A, with CLEAR_VALUE set to 0x5A5A for this run.
6. Ignore while busy, CLEAR_ON_RESET=1: drive write_enable and read_enable during the clear.
   - read_valid is never 1.
   - After the clear, the targeted address reads CLEAR_VALUE.
   - With CLEAR_ON_RESET=0, reset preserves previously written data.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enabled simple-dual-port RAM: controller states,
// lane-count helper and parameter legality check.
package bram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bram_state_t;

  function automatic int lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic bit params_ok(input int data_w, input int byte_w, input int out_reg);
    return (byte_w > 0) && ((data_w % byte_w) == 0) && (out_reg >= 0) && (out_reg <= 1);
  endfunction

endpackage

// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with per-byte write enables, read-valid pipeline,
// optional output register and a post-reset clear engine that fills every entry.
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    OUT_REG        = 0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{1'b0}},
  localparam int                   NUM_LANES      = lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic [NUM_LANES-1:0]  write_byte_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (!params_ok(DATA_WIDTH, BYTE_WIDTH, OUT_REG)) begin : g_bad_params
    $error("bram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH and OUT_REG must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  bram_state_t           r_state;
  bram_state_t           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  w_mem_we;
  logic [NUM_LANES-1:0]  w_mem_be;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_rd_fire;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  // Controller: the clear engine owns the write port until the last entry is filled
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_be    = {NUM_LANES{1'b0}};
    w_mem_waddr = write_addr;
    w_mem_wdata = write_data;
    w_rd_fire   = 1'b0;
    case (r_state)
      CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_be    = {NUM_LANES{1'b1}};
        w_mem_waddr = r_clr_cnt;
        w_mem_wdata = CLEAR_VALUE;
        if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = READY;
        end else begin
          w_state_nxt = CLEAR;
        end
      end
      READY: begin
        w_mem_we  = write_enable;
        w_mem_be  = write_byte_enable;
        w_rd_fire = read_enable;
      end
      default: begin
        w_state_nxt = READY;
      end
    endcase
  end

  // State register and clear address counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR_ON_RESET ? CLEAR : READY;
      r_clr_cnt <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
      end else begin
        r_clr_cnt <= r_clr_cnt;
      end
    end
  end

  // Storage write port; the array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    // Two-stage read: array read, then output register; data holds between reads
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1_data  <= {DATA_WIDTH{1'b0}};
        r_s1_valid <= 1'b0;
        r_rd_data  <= {DATA_WIDTH{1'b0}};
        r_rd_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_rd_fire;
        if (w_rd_fire) begin
          r_s1_data <= r_mem[read_addr];
        end
        r_rd_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rd_data <= r_s1_data;
        end
      end
    end
  end else begin : g_no_out_reg
    // Single-stage read; non-blocking update against the write gives read-first
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd_data  <= {DATA_WIDTH{1'b0}};
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_fire;
        if (w_rd_fire) begin
          r_rd_data <= r_mem[read_addr];
        end
      end
    end
  end

  assign read_data  = r_rd_data;
  assign read_valid = r_rd_valid;
  assign busy       = (r_state == CLEAR);

endmodule

// File: tb/tb_bram_sdp_be.sv
// Randomised and directed bench for bram_sdp_be: three configurations share one
// stimulus stream and are each checked every cycle against a behavioural memory model.
module tb_bram_sdp_be;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  write_addr;
  logic [15:0] write_data;
  logic        write_enable;
  logic [1:0]  write_byte_enable;
  logic [7:0]  read_addr;
  logic        read_enable;
  logic [15:0] o_data  [3];
  logic        o_valid [3];
  logic        o_busy  [3];

  always #5 clk = ~clk;

  bram_sdp_be u_d0 (
    .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable), .write_byte_enable(write_byte_enable),
    .read_addr(read_addr), .read_enable(read_enable),
    .read_data(o_data[0]), .read_valid(o_valid[0]), .busy(o_busy[0])
  );

  bram_sdp_be #(.OUT_REG(1), .CLEAR_VALUE(16'h5A5A)) u_d1 (
    .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable), .write_byte_enable(write_byte_enable),
    .read_addr(read_addr), .read_enable(read_enable),
    .read_data(o_data[1]), .read_valid(o_valid[1]), .busy(o_busy[1])
  );

  bram_sdp_be #(.CLEAR_ON_RESET(1'b0)) u_d2 (
    .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
    .write_enable(write_enable), .write_byte_enable(write_byte_enable),
    .read_addr(read_addr), .read_enable(read_enable),
    .read_data(o_data[2]), .read_valid(o_valid[2]), .busy(o_busy[2])
  );

  // Reference model: one memory image per configuration plus a log of issued reads
  int          lat_k [3] = '{1, 2, 1};
  bit          cor_k [3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] cv_k  [3] = '{16'h0000, 16'h5A5A, 16'h0000};
  logic [15:0] m_mem [3][256];
  int          clr_left [3];
  bit          log_v [3][4];
  logic [15:0] log_d [3][4];
  logic [15:0] e_data  [3];
  bit          e_valid [3];
  int          cyc = 0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      int s;
      int ds;
      s  = cyc % 4;
      ds = (cyc + 5 - lat_k[k]) % 4;
      if (reset) begin
        for (int j = 0; j < 4; j++) log_v[k][j] = 1'b0;
        clr_left[k] = cor_k[k] ? 256 : 0;
        e_data[k]   = 16'h0000;
        e_valid[k]  = 1'b0;
      end else begin
        log_v[k][s] = (clr_left[k] == 0) && read_enable;
        log_d[k][s] = m_mem[k][read_addr];
        if (clr_left[k] > 0) begin
          m_mem[k][256 - clr_left[k]] = cv_k[k];
          clr_left[k]--;
        end else if (write_enable) begin
          for (int b = 0; b < 2; b++)
            if (write_byte_enable[b]) m_mem[k][write_addr][8*b +: 8] = write_data[8*b +: 8];
        end
        if (log_v[k][ds]) begin
          e_valid[k] = 1'b1;
          e_data[k]  = log_d[k][ds];
        end else begin
          e_valid[k] = 1'b0;
        end
      end
    end
    cyc++;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("busy%0d", k), {31'd0, o_busy[k]}, {31'd0, (clr_left[k] > 0)});
      check_eq($sformatf("valid%0d", k), {31'd0, o_valid[k]}, {31'd0, e_valid[k]});
      check_eq($sformatf("data%0d", k), {16'd0, o_data[k]}, {16'd0, e_data[k]});
    end
  endtask

  task automatic idle();
    write_enable      = 1'b0;
    read_enable       = 1'b0;
    write_byte_enable = 2'b00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    write_addr        = a;
    write_data        = d;
    write_byte_enable = be;
    write_enable      = 1'b1;
    step();
    idle();
  endtask

  task automatic rd(input logic [7:0] a);
    read_addr   = a;
    read_enable = 1'b1;
    step();
    read_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        v_seq [6];
    logic [15:0] d_seq [6];
    logic [7:0]  rl_addr [4];

    reset = 1'b1;
    write_addr = 8'h00; write_data = 16'h0000; read_addr = 8'h00;
    idle();
    step();
    step();
    reset = 1'b0;

    // Initial clear; the never-clearing instance is filled through the user port meanwhile
    n = 0;
    while (o_busy[0] && n < 1000) begin
      write_addr = n[7:0]; write_data = 16'($urandom); write_byte_enable = 2'b11; write_enable = 1'b1;
      step();
      n++;
    end
    idle();
    check_eq("t1_busy_len", n, 256);
    rl_addr = '{8'h00, 8'h7F, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      rd(rl_addr[i]);
      check_eq("t1_valid", {31'd0, o_valid[0]}, 32'd1);
      check_eq("t1_data", {16'd0, o_data[0]}, 32'h0000);
      step();
    end

    // Byte lanes
    wr(8'h10, 16'hABCD, 2'b11);
    wr(8'h10, 16'h12EE, 2'b10);
    rd(8'h10);
    check_eq("t2_be10", {16'd0, o_data[0]}, 32'h12CD);
    wr(8'h10, 16'hFFFF, 2'b00);
    rd(8'h10);
    check_eq("t2_be00", {16'd0, o_data[0]}, 32'h12CD);

    // Same-cycle read/write collision returns old word
    wr(8'h20, 16'h1111, 2'b11);
    write_addr = 8'h20; write_data = 16'h2222; write_byte_enable = 2'b11; write_enable = 1'b1;
    read_addr = 8'h20; read_enable = 1'b1;
    step();
    idle();
    check_eq("t3_old", {16'd0, o_data[0]}, 32'h1111);
    rd(8'h20);
    check_eq("t3_new", {16'd0, o_data[0]}, 32'h2222);

    // OUT_REG=1 latency and back-to-back ordering
    for (int i = 1; i <= 4; i++) wr(8'(i), 16'hA000 + 16'(i), 2'b11);
    step();
    for (int i = 0; i < 6; i++) begin
      read_addr   = 8'(i + 1);
      read_enable = (i < 4);
      step();
      v_seq[i] = o_valid[1];
      d_seq[i] = o_data[1];
    end
    idle();
    check_eq("t4_v0", {31'd0, v_seq[0]}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check_eq("t4_v", {31'd0, v_seq[i]}, 32'd1);
      check_eq("t4_d", {16'd0, d_seq[i]}, 32'hA000 + 32'(i));
    end
    check_eq("t4_v5", {31'd0, v_seq[5]}, 32'd0);

    // Random traffic over a small address window to force collisions
    for (int i = 0; i < 300; i++) begin
      write_enable      = 1'($urandom);
      write_addr        = 8'($urandom_range(15, 0));
      write_data        = 16'($urandom);
      write_byte_enable = 2'($urandom);
      read_enable       = 1'($urandom);
      read_addr         = 8'($urandom_range(15, 0));
      step();
    end
    idle();
    step();

    // Mark data in the persistent instance, then reset with a read in flight
    wr(8'h33, 16'hBEEF, 2'b11);
    rd(8'h33);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Restarted clear while the user port is hammered
    n = 0;
    while (o_busy[1] && n < 1000) begin
      write_addr = 8'h44; write_data = 16'h7777; write_byte_enable = 2'b11; write_enable = 1'b1;
      read_addr = 8'($urandom); read_enable = 1'b1;
      step();
      check_eq("t6_nv0", {31'd0, o_valid[0]}, 32'd0);
      check_eq("t6_nv1", {31'd0, o_valid[1]}, 32'd0);
      n++;
    end
    idle();
    check_eq("t5_busy_len", n, 256);
    rd(8'h44);
    check_eq("t6_ign0", {16'd0, o_data[0]}, 32'h0000);
    check_eq("t6_keep2", {16'd0, o_data[2]}, 32'h7777);
    step();
    check_eq("t6_ign1", {16'd0, o_data[1]}, 32'h5A5A);
    rd(8'h33);
    check_eq("t6_persist", {16'd0, o_data[2]}, 32'hBEEF);
    step();

    // Full sweep of the cleared instance
    n = 0;
    for (int i = 0; i < 258; i++) begin
      read_addr   = 8'(i);
      read_enable = (i < 256);
      step();
      if (o_valid[1]) begin
        check_eq("t5_cv", {16'd0, o_data[1]}, 32'h5A5A);
        n++;
      end
    end
    idle();
    check_eq("t5_count", n, 256);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
